// File: rtl/diffamp_offset_cal_ctrl.sv
// SAR offset-calibration controller for the differential amplifier.
// Binary-searches the trim code with inputs shorted, majority-voting the
// synchronized amplifier output per bit. Keeps the result for mission mode
// and supports a configuration bypass of the trim code.
module diffamp_offset_cal_ctrl #(
  parameter int TRIM_W     = 6,
  parameter int SETTLE_CYC = 8,
  parameter int VOTE_N     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cal_start,
  input  logic              cal_abort,
  input  logic              cal_bypass,
  input  logic [TRIM_W-1:0] cfg_trim,
  input  logic              amp_out,
  output logic [TRIM_W-1:0] trim_code,
  output logic              short_en,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_sat
);

  localparam int CNT_MAX = (SETTLE_CYC > VOTE_N) ? SETTLE_CYC : VOTE_N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ONES_W  = $clog2(VOTE_N + 1);
  localparam int IDX_W   = $clog2(TRIM_W);
  localparam logic [TRIM_W-1:0] MID = {1'b1, {(TRIM_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DECIDE, DONE} state_t;

  state_t             state, state_nx;
  logic [TRIM_W-1:0]  work, work_nx, hold, hold_nx, code;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [ONES_W-1:0]  ones, ones_nx;
  logic               amp_s1, amp_s2;
  logic               short_nx, busy_nx, done_nx, sat_nx;

  // Mission/bypass mux is the only combinational path to an output.
  assign trim_code = (state == IDLE) ? (cal_bypass ? cfg_trim : hold) : work;

  // Two-flop synchronizer for the asynchronous amplifier output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amp_s1 <= 1'b0;
      amp_s2 <= 1'b0;
    end else begin
      amp_s1 <= amp_out;
      amp_s2 <= amp_s1;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      work     <= MID;
      hold     <= MID;
      idx      <= '0;
      cnt      <= '0;
      ones     <= '0;
      short_en <= 1'b0;
      cal_busy <= 1'b0;
      cal_done <= 1'b0;
      cal_sat  <= 1'b0;
    end else begin
      state    <= state_nx;
      work     <= work_nx;
      hold     <= hold_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      ones     <= ones_nx;
      short_en <= short_nx;
      cal_busy <= busy_nx;
      cal_done <= done_nx;
      cal_sat  <= sat_nx;
    end
  end

  // Next-state: settle, vote, decide one bit per pass, MSB first.
  always_comb begin
    state_nx = state;
    work_nx  = work;
    hold_nx  = hold;
    idx_nx   = idx;
    cnt_nx   = cnt;
    ones_nx  = ones;
    short_nx = short_en;
    busy_nx  = cal_busy;
    done_nx  = 1'b0;
    sat_nx   = cal_sat;
    code     = work;
    case (state)
      IDLE: begin
        if (cal_start && !cal_bypass) begin
          state_nx = SETTLE;
          idx_nx   = IDX_W'(TRIM_W - 1);
          work_nx  = MID;
          cnt_nx   = CNT_W'(SETTLE_CYC);
          short_nx = 1'b1;
          busy_nx  = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == CNT_W'(1)) begin
          state_nx = SAMPLE;
          cnt_nx   = CNT_W'(VOTE_N);
          ones_nx  = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      SAMPLE: begin
        ones_nx = ones + ONES_W'(amp_s2);
        if (cnt == CNT_W'(1)) state_nx = DECIDE;
        else                  cnt_nx   = cnt - CNT_W'(1);
      end
      DECIDE: begin
        // Majority high means the code sits above the threshold.
        if (ones > ONES_W'(VOTE_N / 2)) code[idx] = 1'b0;
        if (idx == '0) begin
          state_nx = DONE;
          hold_nx  = code;
          done_nx  = 1'b1;
          sat_nx   = (code == '0) || (code == '1);
          short_nx = 1'b0;
        end else begin
          code[idx - IDX_W'(1)] = 1'b1;
          idx_nx   = idx - IDX_W'(1);
          cnt_nx   = CNT_W'(SETTLE_CYC);
          state_nx = SETTLE;
        end
        work_nx = code;
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
    // Abort only while searching; DONE always completes.
    if (cal_abort && (state == SETTLE || state == SAMPLE || state == DECIDE)) begin
      state_nx = IDLE;
      hold_nx  = hold;
      sat_nx   = cal_sat;
      done_nx  = 1'b0;
      short_nx = 1'b0;
      busy_nx  = 1'b0;
    end
  end

endmodule
